// File: rtl/or1k_pic_if.sv
// SPR bus slice seen by the PIC: access/write strobe, address, data and acknowledge.
interface or1k_pic_if;
   logic        spr_access_i;
   logic        spr_we_i;
   logic [15:0] spr_addr_i;
   logic [31:0] spr_dat_i;
   logic        spr_bus_ack;
   logic [31:0] spr_dat_o;

   modport master (
      output spr_access_i,
      output spr_we_i,
      output spr_addr_i,
      output spr_dat_i,
      input  spr_bus_ack,
      input  spr_dat_o
   );

   modport slave (
      input  spr_access_i,
      input  spr_we_i,
      input  spr_addr_i,
      input  spr_dat_i,
      output spr_bus_ack,
      output spr_dat_o
   );
endinterface

// File: rtl/or1k_pic.sv
// OR1K programmable interrupt controller: synchronises and masks 32 external lines into
// PICSR/PICMR and raises the tick and external exception requests.
module or1k_pic #(
   parameter string       PIC_TRIGGER   = "LEVEL",
   parameter int unsigned PIC_NMI_WIDTH = 0,
   parameter int unsigned PIC_SYNC      = 1
) (
   input  logic        clk,
   input  logic        rst,
   or1k_pic_if.slave   spr,
   input  logic [31:0] irq_i,
   input  logic [31:0] spr_ttmr_i,
   input  logic        spr_sr_tee_i,
   input  logic        spr_sr_iee_i,
   output logic [31:0] spr_picmr_o,
   output logic [31:0] spr_picsr_o,
   output logic        tick_irq_o,
   output logic        ext_irq_o
);

   localparam bit EdgeMode = (PIC_TRIGGER == "EDGE");
   // Lines below PIC_NMI_WIDTH can never be masked off.
   localparam logic [31:0] NmiMask =
      (PIC_NMI_WIDTH == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - PIC_NMI_WIDTH));

   localparam logic [10:0] OffPicmr = 11'd0;
   localparam logic [10:0] OffPicsr = 11'd2;

   logic [31:0] irq_s;
   logic [31:0] irq_prev_q;
   logic [31:0] picmr_q, picmr_d;
   logic [31:0] picsr_q, picsr_d;
   logic [31:0] rise;
   logic [10:0] offset;
   logic        picmr_we;
   logic        picsr_we;
   logic        unused;

   // Address bits above the group offset and the non-pending TTMR bits are not needed here.
   assign unused = ^{spr.spr_addr_i[15:11], spr_ttmr_i[31:29], spr_ttmr_i[27:0]};

   if (PIC_SYNC != 0) begin : g_sync
      logic [31:0] sync1_q, sync2_q;

      // Two-flop synchroniser for the asynchronous interrupt lines.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
         end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
         end
      end

      assign irq_s = sync2_q;
   end else begin : g_nosync
      assign irq_s = irq_i;
   end

   assign offset   = spr.spr_addr_i[10:0];
   assign picmr_we = spr.spr_access_i & spr.spr_we_i & (offset == OffPicmr);
   assign picsr_we = spr.spr_access_i & spr.spr_we_i & (offset == OffPicsr);
   assign rise     = irq_s & ~irq_prev_q;

   // Next-state for mask and status; a same-cycle mask write already gates capture.
   always_comb begin
      picmr_d = (picmr_we ? spr.spr_dat_i : picmr_q) | NmiMask;
      picsr_d = picsr_q;
      if (EdgeMode) begin
         // Clear first, then set, so a coincident edge survives a W1C write.
         if (picsr_we) begin
            picsr_d = picsr_d & ~spr.spr_dat_i;
         end
         picsr_d = picsr_d | (rise & picmr_d);
      end else begin
         picsr_d = irq_s & picmr_d;
      end
   end

   // Mask, status and edge-history registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         picmr_q    <= NmiMask;
         picsr_q    <= '0;
         irq_prev_q <= '0;
      end else begin
         picmr_q    <= picmr_d;
         picsr_q    <= picsr_d;
         irq_prev_q <= irq_s;
      end
   end

   // Read mux; unmapped offsets and idle bus return zero.
   always_comb begin
      spr.spr_dat_o = '0;
      if (spr.spr_access_i) begin
         if (offset == OffPicmr) begin
            spr.spr_dat_o = picmr_q;
         end else if (offset == OffPicsr) begin
            spr.spr_dat_o = picsr_q;
         end
      end
   end

   assign spr.spr_bus_ack = spr.spr_access_i;
   assign spr_picmr_o     = picmr_q;
   assign spr_picsr_o     = picsr_q;
   assign ext_irq_o       = spr_sr_iee_i & (|picsr_q);
   assign tick_irq_o      = spr_sr_tee_i & spr_ttmr_i[28];

endmodule

// File: tb/tb_or1k_pic.sv
// Directed bench for or1k_pic: a LEVEL/sync/NMI=2 instance and an EDGE/no-sync instance.
module tb_or1k_pic;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] irq_l, irq_e;
   logic [31:0] ttmr;
   logic        tee, iee;
   logic [31:0] picmr_l, picsr_l, picmr_e, picsr_e;
   logic        tick_l, ext_l, tick_e, ext_e;

   int checks = 0;
   int errors = 0;

   or1k_pic_if bus_l ();
   or1k_pic_if bus_e ();

   or1k_pic #(
      .PIC_TRIGGER   ("LEVEL"),
      .PIC_NMI_WIDTH (2),
      .PIC_SYNC      (1)
   ) u_lvl (
      .clk          (clk),
      .rst          (rst),
      .spr          (bus_l.slave),
      .irq_i        (irq_l),
      .spr_ttmr_i   (ttmr),
      .spr_sr_tee_i (tee),
      .spr_sr_iee_i (iee),
      .spr_picmr_o  (picmr_l),
      .spr_picsr_o  (picsr_l),
      .tick_irq_o   (tick_l),
      .ext_irq_o    (ext_l)
   );

   or1k_pic #(
      .PIC_TRIGGER   ("EDGE"),
      .PIC_NMI_WIDTH (0),
      .PIC_SYNC      (0)
   ) u_edge (
      .clk          (clk),
      .rst          (rst),
      .spr          (bus_e.slave),
      .irq_i        (irq_e),
      .spr_ttmr_i   (ttmr),
      .spr_sr_tee_i (tee),
      .spr_sr_iee_i (iee),
      .spr_picmr_o  (picmr_e),
      .spr_picsr_o  (picsr_e),
      .tick_irq_o   (tick_e),
      .ext_irq_o    (ext_e)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [15:0] addr;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_drive(input bit e, input bit acc, input bit we, input logic [15:0] a,
                            input logic [31:0] d);
      if (e) begin
         bus_e.spr_access_i = acc;
         bus_e.spr_we_i     = we;
         bus_e.spr_addr_i   = a;
         bus_e.spr_dat_i    = d;
      end else begin
         bus_l.spr_access_i = acc;
         bus_l.spr_we_i     = we;
         bus_l.spr_addr_i   = a;
         bus_l.spr_dat_i    = d;
      end
   endtask

   // Called at a negedge; the write lands on the following posedge; returns at next negedge.
   task automatic spr_wr(input bit e, input logic [15:0] a, input logic [31:0] d);
      bus_drive(e, 1'b1, 1'b1, a, d);
      @(negedge clk);
      bus_drive(e, 1'b0, 1'b0, 16'h0, 32'h0);
   endtask

   task automatic spr_rd(input bit e, input logic [15:0] a, output logic [31:0] d,
                         output logic ack);
      bus_drive(e, 1'b1, 1'b0, a, 32'h0);
      #1;
      d   = e ? bus_e.spr_dat_o : bus_l.spr_dat_o;
      ack = e ? bus_e.spr_bus_ack : bus_l.spr_bus_ack;
      @(negedge clk);
      bus_drive(e, 1'b0, 1'b0, 16'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        ack;

      rst   = 1'b1;
      irq_l = '0;
      irq_e = '0;
      ttmr  = '0;
      tee   = 1'b0;
      iee   = 1'b0;
      bus_drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
      bus_drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);

      // Reset state
      #1;
      chk("rst_picmr_l", picmr_l, 32'h3);
      chk("rst_picsr_l", picsr_l, 32'h0);
      chk("rst_picmr_e", picmr_e, 32'h0);
      chk("rst_ack_l", {31'h0, bus_l.spr_bus_ack}, 32'h0);
      chk("rst_dat_l", bus_l.spr_dat_o, 32'h0);
      chk("rst_ext_tick", {30'h0, ext_l, tick_l}, 32'h0);
      cyc(2);
      rst = 1'b0;
      cyc(1);
      iee = 1'b1;

      // SPR decode table on the LEVEL instance (all lines low, so PICSR reads 0)
      tbl.push_back('{1'b1, 16'h4800, 32'h0000_0000, 32'h0});
      tbl.push_back('{1'b0, 16'h4800, 32'h0,         32'h0000_0003});
      tbl.push_back('{1'b1, 16'h4800, 32'hA5A5_0010, 32'h0});
      tbl.push_back('{1'b0, 16'h4800, 32'h0,         32'hA5A5_0013});
      tbl.push_back('{1'b0, 16'h5000, 32'h0,         32'hA5A5_0013});
      tbl.push_back('{1'b1, 16'h4801, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b0, 16'h4800, 32'h0,         32'hA5A5_0013});
      tbl.push_back('{1'b0, 16'h4801, 32'h0,         32'h0});
      tbl.push_back('{1'b1, 16'h4802, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b0, 16'h4802, 32'h0,         32'h0});
      tbl.push_back('{1'b0, 16'h4803, 32'h0,         32'h0});
      tbl.push_back('{1'b1, 16'h4800, 32'h0000_0010, 32'h0});
      tbl.push_back('{1'b0, 16'h4800, 32'h0,         32'h0000_0013});
      foreach (tbl[i]) begin
         if (tbl[i].we) begin
            spr_wr(1'b0, tbl[i].addr, tbl[i].dat);
         end else begin
            spr_rd(1'b0, tbl[i].addr, rd, ack);
            chk($sformatf("spr_vec%0d_dat", i), rd, tbl[i].exp);
            chk($sformatf("spr_vec%0d_ack", i), {31'h0, ack}, 32'h1);
         end
      end

      // LEVEL with sync: three-cycle latency on rise and fall
      irq_l[4] = 1'b1;
      cyc(2); #1;
      chk("lvl_rise_c2", picsr_l, 32'h0);
      chk("lvl_ext_c2", {31'h0, ext_l}, 32'h0);
      cyc(1); #1;
      chk("lvl_rise_c3", picsr_l, 32'h10);
      chk("lvl_ext_c3", {31'h0, ext_l}, 32'h1);
      iee = 1'b0; #1;
      chk("lvl_ext_iee0", {31'h0, ext_l}, 32'h0);
      iee = 1'b1;
      cyc(1);
      spr_wr(1'b0, 16'h4802, 32'hFFFF_FFFF);
      #1 chk("lvl_picsr_wr_ignored", picsr_l, 32'h10);
      cyc(1);
      irq_l[4] = 1'b0;
      cyc(2); #1;
      chk("lvl_fall_c2", picsr_l, 32'h10);
      cyc(1); #1;
      chk("lvl_fall_c3", picsr_l, 32'h0);
      cyc(1);
      irq_l[3] = 1'b1;
      cyc(4); #1;
      chk("lvl_masked_line", picsr_l, 32'h0);
      irq_l[3] = 1'b0;
      cyc(1);

      // NMI lines stay enabled with PICMR written to 0
      spr_wr(1'b0, 16'h4800, 32'h0);
      spr_rd(1'b0, 16'h4800, rd, ack);
      chk("nmi_picmr_rd", rd, 32'h3);
      irq_l[1] = 1'b1;
      cyc(3); #1;
      chk("nmi_picsr", picsr_l, 32'h2);
      irq_l[1] = 1'b0;
      cyc(1);

      // EDGE, no sync: capture, hold after pulse, W1C
      spr_wr(1'b1, 16'h4800, 32'hFFFF_FFFF);
      irq_e[7] = 1'b1;
      cyc(1); #1;
      chk("edge_set", picsr_e, 32'h80);
      chk("edge_ext", {31'h0, ext_e}, 32'h1);
      cyc(1);
      irq_e[7] = 1'b0;
      cyc(2); #1;
      chk("edge_held_low", picsr_e, 32'h80);
      cyc(1);
      spr_wr(1'b1, 16'h4802, 32'h80);
      #1;
      chk("edge_w1c", picsr_e, 32'h0);
      chk("edge_w1c_ext", {31'h0, ext_e}, 32'h0);
      cyc(1);

      // Held-high line sets exactly once
      irq_e[5] = 1'b1;
      cyc(1); #1;
      chk("edge_hold_set", picsr_e, 32'h20);
      cyc(1);
      spr_wr(1'b1, 16'h4802, 32'h20);
      cyc(3); #1;
      chk("edge_hold_once", picsr_e, 32'h0);
      irq_e[5] = 1'b0;
      cyc(1);

      // Set and W1C of the same bit in one cycle: set wins
      irq_e[2] = 1'b1;
      spr_wr(1'b1, 16'h4802, 32'h4);
      #1 chk("edge_collision", picsr_e, 32'h4);
      cyc(1);
      irq_e[6] = 1'b1;
      cyc(1); #1;
      chk("edge_two_bits", picsr_e, 32'h44);
      cyc(1);
      spr_wr(1'b1, 16'h4802, 32'h4);
      #1 chk("edge_w1c_partial", picsr_e, 32'h40);
      cyc(1);
      spr_wr(1'b1, 16'h4800, 32'h0);
      #1 chk("edge_unmask_keeps", picsr_e, 32'h40);
      chk("edge_picmr0", picmr_e, 32'h0);
      cyc(1);
      spr_rd(1'b1, 16'h4802, rd, ack);
      chk("edge_picsr_rd", rd, 32'h40);
      irq_e = '0;

      // Tick request follows TEE and TTMR[28] combinationally
      ttmr = 32'h1000_0000;
      tee  = 1'b0; #1;
      chk("tick_tee0", {30'h0, tick_l, tick_e}, 32'h0);
      tee = 1'b1; #1;
      chk("tick_tee1", {30'h0, tick_l, tick_e}, 32'h3);
      ttmr = 32'hEFFF_FFFF; #1;
      chk("tick_ttmr_clr", {30'h0, tick_l, tick_e}, 32'h0);
      tee = 1'b0;
      ttmr = '0;
      cyc(1);

      // Asynchronous reset mid-operation drops pending state
      spr_wr(1'b0, 16'h4800, 32'hFF);
      irq_l = 32'hFF;
      cyc(3); #1;
      chk("pre_rst_picsr", picsr_l, 32'hFF);
      cyc(1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_picsr_l", picsr_l, 32'h0);
      chk("mid_rst_picmr_l", picmr_l, 32'h3);
      chk("mid_rst_picsr_e", picsr_e, 32'h0);
      chk("mid_rst_picmr_e", picmr_e, 32'h0);
      chk("mid_rst_ext", {30'h0, ext_l, ext_e}, 32'h0);
      irq_l = '0;
      cyc(1);
      rst = 1'b0;
      cyc(4); #1;
      chk("post_rst_no_recover", picsr_l, 32'h0);
      cyc(1);
      spr_rd(1'b0, 16'h4801, rd, ack);
      chk("rd_off1_dat", rd, 32'h0);
      chk("rd_off1_ack", {31'h0, ack}, 32'h1);
      #1;
      chk("idle_ack", {31'h0, bus_l.spr_bus_ack}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
